fsm_moore_counter_param: RTL and testbench
==========================================

# fsm_moore_counter_param

Parametrised Moore up/down/bounce counter built in the two-process style (state register plus combinational next-state logic). It generalises the 2-bit mode-selected counter to WIDTH bits with a programmable terminal value, and adds a bounce (ping-pong) mode, a terminal-count flag and a direction flag. It sits as a generic timing and sequence source beside the other FSM blocks, and feeds enable and strobe logic downstream.

## Interface
- WIDTH, 4: counter width in bits; valid range 2..16.
- MAX, 9: terminal value; must satisfy 1 ≤ MAX ≤ 2^WIDTH−1.
- Clk  in  1  single clock, rising edge.
- Rst  in  1  synchronous, active-high reset, sampled on the Clk rising edge.
- En  in  1  count enable; when 0, state and count freeze.
- X  in  2  mode: 0 hold, 1 up, 2 down, 3 bounce.
- Cuenta  out  WIDTH  registered count.
- Tc  out  1  terminal-count flag (Moore; decoded from registers only).
- Dir  out  1  0 = counting up, 1 = counting down (Moore).

## Operation
- States:
  - S_HOLD: the state after reset.
  - S_UP and S_DOWN: selected by modes 1 and 2.
  - S_BUP and S_BDN: the two bounce directions.
- Priority at each edge: Rst > Load (if compiled in) > En.
- With En=1 at an edge:
  - X=0: go to S_HOLD; count unchanged.
  - X=1: go to S_UP; count = (Cuenta==MAX) ? 0 : Cuenta+1.
  - X=2: go to S_DOWN; count = (Cuenta==0) ? MAX : Cuenta−1.
  - X=3 from a non-bounce state: go to S_BUP and count up from the current value. If Cuenta==MAX, go to S_BDN instead with count MAX−1.
  - X=3 in S_BUP: if Cuenta==MAX, go to S_BDN with count MAX−1; else count+1.
  - X=3 in S_BDN: if Cuenta==0, go to S_BUP with count 1; else count−1.
- Count never exceeds MAX. Bounce never wraps; up and down wrap modulo MAX+1.
- Tc=1 when either of these holds:
  - the state is S_UP or S_BUP and Cuenta==MAX;
  - the state is S_DOWN or S_BDN and Cuenta==0.
  - Tc=0 in S_HOLD.
- Dir=1 in S_DOWN or S_BDN; otherwise 0.

## Timing
- Reset values: Cuenta=0, state S_HOLD, Tc=0, Dir=0. Reset takes effect on the first edge where Rst=1. Reset mid-count discards the count and state in that same cycle.
- Latency: X and En are sampled at edge n. Cuenta, Tc and Dir reflect them after edge n.
- A mode change takes effect on the next enabled edge. There are no intermediate states.
- When En drops, all outputs hold their values, Tc included.
- With MAX=1, bounce alternates 0,1,0,1. Tc is high on every cycle after the first step.

## Configuration
- FSM_COUNTER_LOAD_EN:
  - Defined: adds ports Load (in, 1) and D (in, WIDTH). When Load=1 at an edge, the count becomes min(D, MAX). The state is unchanged and En is ignored that cycle.
  - Undefined: neither port exists, and the behaviour is exactly as described above.

## Structure
- Package fsm_counter_pkg holds:
  - mode codes MODE_HOLD/UP/DOWN/BNC;
  - state encoding localparams S_HOLD, S_UP, S_DOWN, S_BUP, S_BDN (3-bit binary);
  - the state-width constant.
- One sub-module, fsm_counter_next, holds the purely combinational next-state and next-count logic. The top module holds the registers and the Moore output decode.

## Test plan
All scenarios use WIDTH=4, MAX=9.
- Reset: Rst=1 for 2 edges, with En=1 and X=1 → Cuenta=0, Tc=0, Dir=0. Releasing Rst gives Cuenta 1,2,… on the following edges.
- Up wrap: X=1, En=1 for 12 edges → Cuenta runs 1..9,0,1,2. Tc=1 only in the cycle where Cuenta==9.
- Down wrap: start from Cuenta=2 with X=2 → Cuenta 1,0,9,8. Tc=1 when Cuenta==0, and Dir=1 throughout.
- Bounce: from Cuenta=7 with X=3 → Cuenta 8,9,8,7,…,0,1. Dir goes 0→1 after 9 and 1→0 after 0. Tc is high at 9 and at 0.
- En and hold: in up mode at Cuenta=4, drop En for 3 cycles → Cuenta stays 4. Setting X=0 with En=1 → Cuenta stays 4 and Tc=0.
- Mid-operation reset and load: assert Rst at Cuenta=6 in bounce mode → next Cuenta=0 and state S_HOLD. With FSM_COUNTER_LOAD_EN defined, Load=1 with D=13 → Cuenta=9; Load takes priority over En=1 with X=1.

Source files
------------

// File: rtl/fsm_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_counter_pkg
//  Description : Shared mode codes, state encoding and state width for the
//                parametrised Moore up/down/bounce counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package fsm_counter_pkg;

    // Width of the binary state encoding
    localparam int STATE_W = 3;

    // Mode codes carried on the X input
    localparam logic [1:0] MODE_HOLD = 2'd0;
    localparam logic [1:0] MODE_UP   = 2'd1;
    localparam logic [1:0] MODE_DOWN = 2'd2;
    localparam logic [1:0] MODE_BNC  = 2'd3;

    // Counter states; the two bounce directions are separate states so that
    // the direction flag is a pure decode of the state register
    typedef enum logic [STATE_W-1:0] {
        S_HOLD = 3'd0,
        S_UP   = 3'd1,
        S_DOWN = 3'd2,
        S_BUP  = 3'd3,
        S_BDN  = 3'd4
    } state_t;

endpackage : fsm_counter_pkg
`default_nettype wire

// File: rtl/fsm_counter_next.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_counter_next
//  Description : Purely combinational next-state / next-count logic for the
//                Moore up/down/bounce counter. Holds everything when en_i=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module fsm_counter_next
    import fsm_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MAX   = 9
) (
    input  state_t             state_i,
    input  logic [WIDTH-1:0]   cnt_i,
    input  logic               en_i,
    input  logic [1:0]         x_i,
    output state_t             state_o,
    output logic [WIDTH-1:0]   cnt_o
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    logic w_at_max;
    logic w_at_zero;

    assign w_at_max  = (cnt_i == MAX_V);
    assign w_at_zero = (cnt_i == '0);

    // Next state and count from current state, count, mode and enable
    always_comb begin
        state_o = state_i;
        cnt_o   = cnt_i;
        if (en_i) begin
            case (x_i)
                MODE_HOLD: begin
                    state_o = S_HOLD;
                end
                MODE_UP: begin
                    state_o = S_UP;
                    cnt_o   = w_at_max ? '0 : cnt_i + ONE_V;
                end
                MODE_DOWN: begin
                    state_o = S_DOWN;
                    cnt_o   = w_at_zero ? MAX_V : cnt_i - ONE_V;
                end
                default: begin
                    // Bounce: only S_BDN keeps counting down; every other
                    // state (including entry from non-bounce modes) goes up
                    // and turns around at MAX without wrapping.
                    if (state_i == S_BDN) begin
                        if (w_at_zero) begin
                            state_o = S_BUP;
                            cnt_o   = ONE_V;
                        end else begin
                            state_o = S_BDN;
                            cnt_o   = cnt_i - ONE_V;
                        end
                    end else begin
                        if (w_at_max) begin
                            state_o = S_BDN;
                            cnt_o   = MAX_V - ONE_V;
                        end else begin
                            state_o = S_BUP;
                            cnt_o   = cnt_i + ONE_V;
                        end
                    end
                end
            endcase
        end
    end

endmodule : fsm_counter_next
`default_nettype wire

// File: rtl/fsm_moore_counter_param.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_moore_counter_param
//  Description : Parametrised Moore up/down/bounce counter with terminal-count
//                and direction flags. State/count registers and the Moore
//                output decode live here; next-state logic is in
//                fsm_counter_next.
//                Optional macro FSM_COUNTER_LOAD_EN adds a synchronous
//                parallel load (Load, D) that saturates at MAX.
//  Revision    : 1.0 - initial release
// ============================================================================
module fsm_moore_counter_param
    import fsm_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MAX   = 9
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               En,
    input  logic [1:0]         X,
`ifdef FSM_COUNTER_LOAD_EN
    input  logic               Load,
    input  logic [WIDTH-1:0]   D,
`endif
    output logic [WIDTH-1:0]   Cuenta,
    output logic               Tc,
    output logic               Dir
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   cnt_q;
    logic [WIDTH-1:0]   cnt_d;

    fsm_counter_next #(
        .WIDTH (WIDTH),
        .MAX   (MAX)
    ) u_next (
        .state_i (state_q),
        .cnt_i   (cnt_q),
        .en_i    (En),
        .x_i     (X),
        .state_o (state_d),
        .cnt_o   (cnt_d)
    );

    // State and count registers: reset first, then load, then normal stepping
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
        end
`ifdef FSM_COUNTER_LOAD_EN
        else if (Load) begin
            cnt_q   <= (D > MAX_V) ? MAX_V : D;
        end
`endif
        else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore outputs decoded from registers only
    always_comb begin
        Tc  = 1'b0;
        Dir = 1'b0;
        case (state_q)
            S_UP, S_BUP:   Tc = (cnt_q == MAX_V);
            S_DOWN, S_BDN: begin
                Tc  = (cnt_q == '0);
                Dir = 1'b1;
            end
            default: ;
        endcase
    end

    assign Cuenta = cnt_q;

endmodule : fsm_moore_counter_param
`default_nettype wire

// File: tb/tb_fsm_moore_counter_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fsm_moore_counter_param
//  Description : Directed self-checking bench for fsm_moore_counter_param
//                (WIDTH=4, MAX=9). Load scenario runs when
//                FSM_COUNTER_LOAD_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_moore_counter_param;

    logic       Clk;
    logic       Rst;
    logic       En;
    logic [1:0] X;
    logic [3:0] Cuenta;
    logic       Tc;
    logic       Dir;
`ifdef FSM_COUNTER_LOAD_EN
    logic       Load;
    logic [3:0] D;
`endif

    int total;
    int bad;

    fsm_moore_counter_param #(
        .WIDTH (4),
        .MAX   (9)
    ) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .En     (En),
        .X      (X),
`ifdef FSM_COUNTER_LOAD_EN
        .Load   (Load),
        .D      (D),
`endif
        .Cuenta (Cuenta),
        .Tc     (Tc),
        .Dir    (Dir)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Single comparison point for every check
    task automatic chk(input string tag, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Apply inputs, take one edge, sample 1 ns later and check all outputs
    task automatic step(input string tag, input logic rst, input logic en,
                        input logic [1:0] x, input int e_cnt, input int e_tc,
                        input int e_dir);
        Rst = rst;
        En  = en;
        X   = x;
        @(posedge Clk);
        #1;
        chk({tag, ".cnt"}, int'(Cuenta), e_cnt);
        chk({tag, ".tc"},  int'(Tc),     e_tc);
        chk({tag, ".dir"}, int'(Dir),    e_dir);
    endtask

    // Hand-computed expected sequences
    int up_cnt [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int up_tc  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    int dn_cnt [5]  = '{1, 0, 9, 8, 7};
    int dn_tc  [5]  = '{0, 1, 0, 0, 0};
    int bn_cnt [12] = '{8, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    int bn_tc  [12] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    int bn_dir [12] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};

    initial begin
        total = 0;
        bad   = 0;
        Rst   = 1'b1;
        En    = 1'b1;
        X     = 2'd1;
`ifdef FSM_COUNTER_LOAD_EN
        Load  = 1'b0;
        D     = 4'd0;
`endif

        // Reset held for two edges while up mode is requested
        step("rst0", 1'b1, 1'b1, 2'd1, 0, 0, 0);
        step("rst1", 1'b1, 1'b1, 2'd1, 0, 0, 0);

        // Up count with wrap at 9
        for (int i = 0; i < 12; i++)
            step($sformatf("up%0d", i), 1'b0, 1'b1, 2'd1, up_cnt[i], up_tc[i], 0);

        // Down count from 2 with wrap to 9, ending at 7
        for (int i = 0; i < 5; i++)
            step($sformatf("dn%0d", i), 1'b0, 1'b1, 2'd2, dn_cnt[i], dn_tc[i], 1);

        // Bounce from 7: up to 9, down to 0, back up
        for (int i = 0; i < 12; i++)
            step($sformatf("bn%0d", i), 1'b0, 1'b1, 2'd3, bn_cnt[i], bn_tc[i], bn_dir[i]);

        // Up to 4, freeze with En low, then hold mode
        step("u2", 1'b0, 1'b1, 2'd1, 2, 0, 0);
        step("u3", 1'b0, 1'b1, 2'd1, 3, 0, 0);
        step("u4", 1'b0, 1'b1, 2'd1, 4, 0, 0);
        for (int i = 0; i < 3; i++)
            step($sformatf("en0_%0d", i), 1'b0, 1'b0, 2'd1, 4, 0, 0);
        step("hold", 1'b0, 1'b1, 2'd0, 4, 0, 0);

        // Climb to 9 and check Tc persists with En low
        for (int i = 5; i <= 9; i++)
            step($sformatf("up2_%0d", i), 1'b0, 1'b1, 2'd1, i, (i == 9) ? 1 : 0, 0);
        step("tchold0", 1'b0, 1'b0, 2'd2, 9, 1, 0);
        step("tchold1", 1'b0, 1'b0, 2'd3, 9, 1, 0);

        // Bounce entered at MAX from S_UP turns straight down
        step("bmax", 1'b0, 1'b1, 2'd3, 8, 0, 1);
        step("bm7",  1'b0, 1'b1, 2'd3, 7, 0, 1);
        step("bm6",  1'b0, 1'b1, 2'd3, 6, 0, 1);

        // Mid-count reset, then confirm S_HOLD (Tc/Dir low at count 0)
        step("mrst", 1'b1, 1'b1, 2'd3, 0, 0, 0);
        step("post", 1'b0, 1'b0, 2'd3, 0, 0, 0);
        step("bzero", 1'b0, 1'b1, 2'd3, 1, 0, 0);

`ifdef FSM_COUNTER_LOAD_EN
        // Load saturates at MAX, overrides En, leaves state (S_BUP) alone
        Load = 1'b1;
        D    = 4'd13;
        step("load", 1'b0, 1'b1, 2'd1, 9, 1, 0);
        Load = 1'b0;
        step("aftld", 1'b0, 1'b1, 2'd1, 0, 0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_fsm_moore_counter_param
`default_nettype wire
